modexp_arbiter: RTL and testbench
=================================

MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one modular-exponentiation engine (2..8).
REQ-002 Parameter WIDTH, default 16, operand and result width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with MODEXP_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester job valid.
REQ-007 req_ready  output  NUM_REQ  per-requester job accepted (one-hot or zero).
REQ-008 req_msg, req_exp, req_mod  input  NUM_REQ*WIDTH each  packed operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 eng_start  output  1  single-cycle engine launch pulse.
REQ-010 eng_base, eng_exp, eng_mod  output  WIDTH each  engine operands, held stable from eng_start until eng_done.
REQ-011 eng_done  input  1  engine completion pulse; eng_result  input  WIDTH  valid with eng_done.
REQ-012 rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  clog2(NUM_REQ); rsp_data  output  WIDTH; rsp_err  output  1.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when any req_valid high.
REQ-014 Arbitration round-robin: search starts at (last granted id + 1) mod NUM_REQ; after reset pointer is NUM_REQ-1 so requester 0 wins first.
REQ-015 In IDLE with a winner, req_ready[winner] high for exactly one cycle; operands and id latched that cycle.
REQ-016 ISSUE: eng_start high one cycle, FSM to WAIT; launch latency = 1 cycle after acceptance.
REQ-017 Latched req_mod == 0: engine not started; ISSUE->RESP with rsp_err=1, rsp_data=0.
REQ-018 WAIT: on eng_done capture eng_result into rsp_data, rsp_err=0, go RESP; eng_done outside WAIT ignored.
REQ-019 RESP: rsp_valid held with stable rsp_id/rsp_data/rsp_err until rsp_valid && rsp_ready; then IDLE.
REQ-020 One job in flight; req_ready all zero outside IDLE; withdrawal of req_valid by a non-granted requester legal.
REQ-021 eng_done coincident with eng_start ignored (WAIT not yet entered).
REQ-022 Back-to-back: a job may be accepted the cycle after response handshake (IDLE entry), minimum 4 cycles per job plus engine time.

Reset
REQ-023 On reset: FSM IDLE, req_ready 0, eng_start 0, eng operands 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, RR pointer NUM_REQ-1.
REQ-024 Reset mid-job abandons the job without response; a later stray eng_done is ignored.

Configuration
REQ-025 MODEXP_ARB_TIMEOUT_EN defined: WAIT cycle counter; reaching TIMEOUT_CYCLES without eng_done goes to RESP with rsp_err=1, rsp_data=0; eng_done on the same cycle wins (normal result).
REQ-026 MODEXP_ARB_TIMEOUT_EN undefined: no counter, WAIT exits only on eng_done, TIMEOUT_CYCLES unused.

Structure
REQ-027 Shared package modexp_pkg: FSM state encoding, rsp_err codes, default WIDTH constant.
REQ-028 Sub-module rr_arbiter (NUM_REQ request vector, pointer in, one-hot grant out), combinational.

Verification
REQ-029 Single job req 0: msg=4, exp=13, mod=497, engine model -> rsp_id=0, rsp_data=445, rsp_err=0.
REQ-030 All 4 requesters valid continuously -> grant order 0,1,2,3,0; each req_ready pulse one cycle.
REQ-031 req 2 with mod=0 -> no eng_start, rsp_id=2, rsp_err=1, rsp_data=0.
REQ-032 rsp_ready low 10 cycles -> rsp fields stable, no new req_ready until handshake.
REQ-033 Reset asserted in WAIT, then eng_done -> no rsp_valid; next job from requester 0 served normally.
REQ-034 With MODEXP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never done -> rsp_err=1 exactly 16 cycles after WAIT entry.

Source files
------------

// File: rtl/modexp_pkg.sv
// modexp_pkg: FSM encoding, response error codes and default width shared by modexp_arbiter
package modexp_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;
  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts one past the last granted id
module rr_arbiter import modexp_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant
);
  // scan farthest-first so the nearest requester after the pointer is written last and wins
  always_comb begin
    o_grant = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) o_grant = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
  end
endmodule

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin front end sharing one modexp engine; MODEXP_ARB_TIMEOUT_EN adds a WAIT watchdog
module modexp_arbiter import modexp_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_msg,
  input  logic [NUM_REQ*WIDTH-1:0]     req_exp,
  input  logic [NUM_REQ*WIDTH-1:0]     req_mod,
  output logic                         eng_start,
  output logic [WIDTH-1:0]             eng_base,
  output logic [WIDTH-1:0]             eng_exp,
  output logic [WIDTH-1:0]             eng_mod,
  input  logic                         eng_done,
  input  logic [WIDTH-1:0]             eng_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         rsp_err
);
  localparam int IW = $clog2(NUM_REQ);
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, w_win;
  logic [NUM_REQ-1:0] w_grant;
  logic w_accept, w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.i_req(req_valid), .i_ptr(r_ptr), .o_grant(w_grant));

  // one-hot grant to requester index
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_grant[i]) w_win = IW'(i);
  end

  assign w_accept = r_state == S_IDLE && |req_valid && !reset;

`ifdef MODEXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // cycles spent in WAIT, cleared whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
  assign w_timeout = r_state == S_WAIT && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;

  // next state and handshake strobes; a zero modulus skips the engine entirely
  always_comb begin
    w_next = r_state;
    req_ready = '0;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = w_accept ? w_grant : '0;
        w_next = w_accept ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        eng_start = eng_mod != '0;
        w_next = eng_mod != '0 ? S_WAIT : S_RESP;
      end
      S_WAIT: w_next = eng_done || w_timeout ? S_RESP : S_WAIT;
      default: begin
        rsp_valid = 1'b1;
        w_next = rsp_ready ? S_IDLE : S_RESP;
      end
    endcase
  end

  // latch the winning job on acceptance, then the response; engine done beats the watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= IW'(NUM_REQ - 1);
      eng_base <= '0;
      eng_exp  <= '0;
      eng_mod  <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= ERR_NONE;
    end else begin
      if (w_accept) begin
        r_ptr    <= w_win;
        rsp_id   <= w_win;
        eng_base <= req_msg[w_win*WIDTH +: WIDTH];
        eng_exp  <= req_exp[w_win*WIDTH +: WIDTH];
        eng_mod  <= req_mod[w_win*WIDTH +: WIDTH];
      end
      if (r_state == S_ISSUE && eng_mod == '0) begin
        rsp_data <= '0;
        rsp_err  <= ERR_FAIL;
      end
      if (r_state == S_WAIT && (eng_done || w_timeout)) begin
        rsp_data <= eng_done ? eng_result : '0;
        rsp_err  <= eng_done ? ERR_NONE : ERR_FAIL;
      end
    end
  end
endmodule

// File: tb/tb_modexp_arbiter.sv
// tb_modexp_arbiter: scoreboard bench with a transaction-level arbiter/engine model
module tb_modexp_arbiter;
  localparam int N = 4, W = 16, TO = 16;
  logic clk = 1'b0, reset;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_msg, req_exp, req_mod;
  logic eng_start, eng_done, rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] eng_base, eng_exp, eng_mod, eng_result, rsp_data;
  logic [1:0] rsp_id;
  typedef struct { int id; logic [W-1:0] data; logic err; } rsp_t;
  rsp_t exp_q[$];
  int grants[$];
  int checks = 0, errors = 0, cyc = 0, last = N - 1, start_cyc = 0, start_seen = 0;
  int starts = 0, readies = 0, last_id = 0;
  bit busy = 0, need_start = 0, started = 0, hang_job = 0, rsp_seen = 0;
  bit refill = 0, rnd = 0, eng_hang = 0;
  logic [W-1:0] cb, ce, cm, last_data;
  logic last_err;
  logic [N-1:0] acc = '0;

  modexp_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_exp(req_exp), .req_mod(req_mod),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    longint r, x;
    if (m == 0) return '0;
    r = 1 % longint'(m);
    x = longint'(b) % longint'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % longint'(m);
      x = (x * x) % longint'(m);
    end
    return r[W-1:0];
  endfunction

  function automatic logic [N-1:0] predict(input logic [N-1:0] v, input int lst);
    for (int k = 1; k <= N; k++)
      if (v[(lst + k) % N]) return N'(1) << ((lst + k) % N);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_mod();
    return $urandom_range(0, 7) == 0 ? '0 : W'($urandom);
  endfunction

  task automatic post(input int i, input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] md);
    req_valid[i] = 1'b1;
    req_msg[i*W +: W] = m;
    req_exp[i*W +: W] = e;
    req_mod[i*W +: W] = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (refill) post(i, W'($urandom), W'($urandom), rand_mod());
        else req_valid[i] = 1'b0;
      end else if (rnd) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) post(i, W'($urandom), W'($urandom), rand_mod());
        else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
      end
    end
    if (rnd) rsp_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || req_valid != 0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // engine model: computes from the operands it is handed, sometimes fires a stray done with the start
  initial begin
    logic [W-1:0] b, e, m;
    int d;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        b = eng_base; e = eng_exp; m = eng_mod;
        if ($urandom_range(0, 2) == 0) begin
          eng_done = 1'b1;
          eng_result = ~modexp(b, e, m);
        end
        @(posedge clk);
        #1 eng_done = 1'b0;
        while (eng_hang) @(posedge clk);
        #1;
        d = $urandom_range(0, 6);
        repeat (d) begin @(posedge clk); #1; end
        eng_done = 1'b1;
        eng_result = modexp(b, e, m);
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // monitor and scoreboard, sampled on the falling edge
  initial begin
    logic [N-1:0] g;
    int id;
    rsp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_ops", {eng_base, eng_exp, eng_mod}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_err}, 0);
        busy = 0; started = 0; hang_job = 0; last = N - 1; acc = '0;
        exp_q.delete();
      end else begin
        chk("eng_start", eng_start, busy && need_start && cyc == start_cyc);
        if (eng_start) begin
          started = 1;
          start_seen = cyc;
          starts++;
        end
        if (busy && started) chk("eng_ops", {eng_base, eng_exp, eng_mod}, {cb, ce, cm});
        acc = req_ready;
        if (req_ready != 0) begin
          readies++;
          for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
        end
        if (busy) chk("ready_busy", req_ready, 0);
        else begin
          g = predict(req_valid, last);
          chk("grant", req_ready, g);
          if (g != 0) begin
            id = 0;
            for (int i = 0; i < N; i++) if (g[i]) id = i;
            last = id;
            busy = 1;
            cb = req_msg[id*W +: W]; ce = req_exp[id*W +: W]; cm = req_mod[id*W +: W];
            need_start = cm != 0;
            start_cyc = cyc + 1;
            started = 0;
            hang_job = eng_hang;
            rsp_seen = 0;
            e.id = id;
            e.err = cm == 0 || hang_job;
            e.data = e.err ? '0 : modexp(cb, ce, cm);
            exp_q.push_back(e);
          end
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            e = exp_q[0];
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
`ifdef MODEXP_ARB_TIMEOUT_EN
            if (hang_job && !rsp_seen) chk("timeout_latency", cyc - (start_seen + 1), TO);
`endif
            rsp_seen = 1;
            if (rsp_ready) begin
              last_id = rsp_id; last_data = rsp_data; last_err = rsp_err;
              void'(exp_q.pop_front());
              busy = 0;
              started = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int n, s0, r0;
    reset = 1'b1;
    req_valid = '0; req_msg = '0; req_exp = '0; req_mod = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    post(0, 16'd4, 16'd13, 16'd497);
    wait_idle(200);
    chk("single_id", last_id, 0);
    chk("single_data", last_data, 445);
    chk("single_err", last_err, 0);

    do_reset();
    grants.delete();
    refill = 1;
    for (int i = 0; i < N; i++) post(i, W'($urandom), W'($urandom), W'($urandom_range(1, 65535)));
    n = 0;
    while (grants.size() < 5 && n < 500) begin tick(); n++; end
    refill = 0;
    wait_idle(500);
    chk("rr_grants_seen", grants.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk($sformatf("rr_order%0d", i), grants[i], i % N);

    s0 = starts;
    post(2, 16'h1234, 16'h0005, 16'h0000);
    wait_idle(100);
    chk("mod0_no_start", starts - s0, 0);
    chk("mod0_id", last_id, 2);
    chk("mod0_data", last_data, 0);
    chk("mod0_err", last_err, 1);

    rsp_ready = 1'b0;
    post(0, 16'd7, 16'd3, 16'd101);
    post(1, 16'd9, 16'd2, 16'd1000);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("stall_rsp_seen", rsp_valid, 1);
    r0 = readies;
    repeat (10) tick();
    chk("stall_no_ready", readies - r0, 0);
    rsp_ready = 1'b1;
    wait_idle(200);

    eng_hang = 1;
    post(1, 16'd5, 16'd6, 16'd77);
    n = 0;
    while (!started && n < 50) begin tick(); n++; end
    chk("hang_started", started, 1);
    repeat (3) tick();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    reset = 1'b0;
    eng_hang = 0;
    repeat (12) tick();
    post(0, 16'd4, 16'd13, 16'd497);
    wait_idle(200);
    chk("after_rst_id", last_id, 0);
    chk("after_rst_data", last_data, 445);

`ifdef MODEXP_ARB_TIMEOUT_EN
    eng_hang = 1;
    post(3, 16'd3, 16'd5, 16'd7);
    wait_idle(100);
    chk("timeout_id", last_id, 3);
    chk("timeout_data", last_data, 0);
    chk("timeout_err", last_err, 1);
    eng_hang = 0;
    repeat (12) tick();
`endif

    rnd = 1;
    repeat (800) tick();
    rnd = 0;
    rsp_ready = 1'b1;
    wait_idle(2000);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
